// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core front end: widths, reset PC and the
// fetch state encoding used by ifu_fetch.
package npc_pkg;

  localparam int                XLEN      = 32;
  localparam logic [XLEN-1:0]   RESET_PC  = 32'h8000_0000;
  localparam logic [XLEN-1:0]   ZERO_INST = '0;

  // Fetch state encoding, kept as plain constants so older code can compare against it.
  localparam logic [1:0] FS_REQ      = 2'd0;
  localparam logic [1:0] FS_RESP     = 2'd1;
  localparam logic [1:0] FS_OUT      = 2'd2;
  localparam logic [1:0] FS_WAIT_NPC = 2'd3;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch: owns the PC, reads one word from imem,
// hands it to decode, then waits for the next PC. One instruction in flight.
module ifu_fetch #(
  parameter int                XLEN     = npc_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(npc_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  output logic            imem_resp_ready,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc,
  output logic [31:0]     fetch_count
);

  import npc_pkg::*;

  logic [1:0]      state;
  logic [XLEN-1:0] pc;

  // Handshake outputs come straight from the state register so no input
  // can ripple combinationally into a valid/ready.
  assign imem_req_valid  = (state == FS_REQ);
  assign imem_resp_ready = (state == FS_RESP);
  assign inst_valid      = (state == FS_OUT);
  assign imem_req_addr   = pc;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FS_REQ;
      pc          <= RESET_PC;
      inst        <= '0;
      inst_pc     <= '0;
      inst_fault  <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        FS_REQ: begin
          if (imem_req_ready) state <= FS_RESP;
        end
        FS_RESP: begin
          if (imem_resp_valid) begin
            inst       <= imem_resp_err ? XLEN'(ZERO_INST) : imem_resp_data;
            inst_fault <= imem_resp_err;
            inst_pc    <= pc;
            state      <= FS_OUT;
          end
        end
        FS_OUT: begin
          if (inst_ready) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= FS_WAIT_NPC;
          end
        end
        FS_WAIT_NPC: begin
          if (npc_valid) begin
            pc <= npc;
            if (is_word_aligned(npc[1:0])) begin
              state <= FS_REQ;
            end else begin
              // Misaligned target faults locally; memory is never touched.
              inst       <= XLEN'(ZERO_INST);
              inst_fault <= 1'b1;
              inst_pc    <= npc;
              state      <= FS_OUT;
            end
          end
        end
        default: state <= FS_REQ;
      endcase
    end
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Multi-cycle instruction fetch unit for the NPC core. Replaces the single-cycle combinational fetch.
- Owns the architectural PC.
- Issues word reads to instruction memory over a valid/ready request/response handshake.
- Hands each fetched instruction to the decode stage over a valid/ready interface.
- Waits for the next-PC from the execute/commit path before fetching again (one instruction in flight, no prediction).

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
XLEN, 32, address/data width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_resp_valid  in  1  read data valid
imem_resp_ready  out  1  fetch accepts response
imem_resp_data  in  XLEN  instruction word
imem_resp_err  in  1  access fault on this response
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes instruction
inst  out  XLEN  instruction word (0 on fault)
inst_pc  out  XLEN  PC of inst
inst_fault  out  1  fetch fault (access error or misaligned PC)
npc_valid  in  1  next-PC available from execute/commit
npc  in  XLEN  next PC
fetch_count  out  32  number of instructions handed to decode

Behaviour:
- Reset (rst sampled high at posedge):
  - state=REQ, pc=RESET_PC.
  - inst_valid=0, inst=0, inst_pc=0, inst_fault=0, fetch_count=0.
  - rst dominates everything, including a mid-transaction reset. An outstanding memory response arriving after reset is dropped.
- States: REQ, RESP, OUT, WAIT_NPC.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Address and valid are held stable until imem_req_ready.
  - On the handshake cycle, go to RESP.
- RESP:
  - imem_resp_ready=1, and only in this state.
  - On imem_resp_valid, register the result and go to OUT:
    - inst <= err ? 0 : data
    - inst_fault <= err
    - inst_pc <= pc
  - A response in the same cycle as the request handshake is not allowed. The earliest response is the cycle after the request handshake.
- OUT:
  - inst_valid=1; inst, inst_pc and inst_fault are held stable until inst_ready.
  - On the handshake, fetch_count increments (wraps at 2^32) and the state goes to WAIT_NPC.
  - inst_valid deasserts the next cycle.
- WAIT_NPC: on npc_valid, pc <= npc.
  - If npc[1:0]==0, go to REQ.
  - Otherwise (misaligned), go directly to OUT with inst_fault=1, inst=0, inst_pc=npc. No memory request is issued.
- npc_valid is ignored in REQ, RESP and OUT. imem_resp_valid is ignored outside RESP.
- Outputs imem_req_valid, imem_resp_ready and inst_valid are decoded from the state register only. There is no combinational path from any input to these outputs.
- Minimum loop, zero-wait memory and immediate ready/npc: 4 cycles per instruction (REQ, RESP, OUT, WAIT_NPC).
- Memory responses carry no ID. The single outstanding request guarantees ordering.

Decomposition:
- Shared package npc_pkg:
  - fetch state enum (REQ, RESP, OUT, WAIT_NPC)
  - RESET_PC constant
  - XLEN
  - NOP/zero instruction constant
- No sub-module: state register, PC register, output registers and counter fit in one module.
- The bench supplies a separate parameterised-latency imem model; it is not part of the RTL.

Test Plan:
- Reset then zero-wait memory, mem[0x8000_0000]=0x00000413, inst_ready=1, npc=0x8000_0004 → imem_req_addr=0x8000_0000 on first post-reset cycle; inst=0x00000413, inst_pc=0x8000_0000 valid 2 cycles later; next request addr 0x8000_0004; fetch_count=1.
- Request backpressure: imem_req_ready low 3 cycles → req_valid and addr stable all 3 cycles, exactly one request accepted.
- Decode backpressure: inst_ready low 5 cycles in OUT → inst/inst_pc/inst_fault unchanged; fetch_count increments only on the handshake.
- imem_resp_err=1 on fetch at 0x8000_0010 → inst=0, inst_fault=1, inst_pc=0x8000_0010; the next fetch after npc has fault cleared.
- npc=0x8000_0006 → no imem_req_valid; OUT with inst_fault=1, inst_pc=0x8000_0006 the cycle after npc_valid.
- rst asserted in RESP, with the response arriving the cycle after → response ignored, inst_valid stays 0, the next request is at RESET_PC, fetch_count=0.
